sram_like_data_responder: RTL and testbench

Slave/responder end of the CPU data-side SRAM-like interface (req/addr_ok/data_ok), driven by the pipeline's EXE stage (request) and consumed by the MEM stage (data_ok/rdata).
Accepts read and write requests in order and performs each on a single-port synchronous RAM (1-cycle read latency).
Returns exactly one data_ok per accepted request, in order, after a fixed configurable latency.
Stall inputs let the bench produce address-phase and response-phase backpressure.

---
 rtl/sram_like_pkg.sv | 18 +
 rtl/sram_like_rsp_fifo.sv | 70 +++++++
 rtl/sram_like_data_responder.sv | 69 ++++++
 tb/tb_sram_like_data_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// Shared types for the SRAM-like data-side responder: size encodings and the
// response FIFO entry layout.
package sram_like_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  typedef struct packed {
    logic        wr;
    logic [3:0]  timer;
    logic        data_vld;
    logic [31:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/sram_like_rsp_fifo.sv
// In-order response FIFO: holds outstanding entries, ages their latency timers
// and captures RAM read data on the cycle after each handshake.
module sram_like_rsp_fifo
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_wr,
  input  logic             pop,
  input  logic [31:0]      ram_rdata,
  output logic [CNT_W-1:0] count,
  output rsp_entry_t       head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] TIMER_INIT = 4'(LATENCY - 1);

  rsp_entry_t       ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, cap_ptr_q;
  logic             cap_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cap_ptr_q <= '0;
      cap_q     <= 1'b0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cap_q     <= push;
      cap_ptr_q <= wr_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && ent_q[i].timer != 4'd0) ent_q[i].timer <= ent_q[i].timer - 4'd1;
      end
      // RAM data for the entry pushed last cycle is valid now.
      if (cap_q) begin
        ent_q[cap_ptr_q].data_vld <= 1'b1;
        if (!ent_q[cap_ptr_q].wr) ent_q[cap_ptr_q].data <= ram_rdata;
      end
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= next_ptr(rd_ptr_q);
      end
      if (push) begin
        ent_q[wr_ptr_q] <= '{wr: push_wr, timer: TIMER_INIT, data_vld: 1'b0, data: 32'h0};
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (push && !pop) count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign head  = ent_q[rd_ptr_q];

endmodule

// File: rtl/sram_like_data_responder.sv
// Responder end of the CPU data-side SRAM-like interface: accepts requests onto
// a synchronous RAM and returns one in-order data_ok per request after LATENCY.
module sram_like_data_responder
  import sram_like_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [31:0]       data_sram_rdata,
  input  logic              stall_req,
  input  logic              stall_rsp,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count;
  rsp_entry_t       head;
  logic             hs;
  logic             issue;

  // No bypass from a same-cycle pop: a full FIFO never accepts.
  assign data_sram_addr_ok = !reset && !stall_req && (count < CNT_W'(DEPTH));
  assign hs                = data_sram_req && data_sram_addr_ok;

  assign ram_en    = hs;
  assign ram_we    = (hs && data_sram_wr) ? data_sram_wstrb : 4'b0000;
  assign ram_addr  = data_sram_addr[ADDR_W+1:2];
  assign ram_wdata = data_sram_wdata;

  assign issue = !reset && (count != '0) && (head.timer == 4'd0) && head.data_vld && !stall_rsp;
  assign data_sram_data_ok = issue;
  assign data_sram_rdata   = (issue && !head.wr) ? head.data : 32'h0;

  // Size and byte offset are informational; wstrb selects bytes.
  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  sram_like_rsp_fifo #(
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY),
    .CNT_W  (CNT_W)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (hs),
    .push_wr  (data_sram_wr),
    .pop      (issue),
    .ram_rdata(ram_rdata),
    .count    (count),
    .head     (head)
  );

endmodule

// File: tb/tb_sram_like_data_responder.sv
// Bench for sram_like_data_responder: directed vector table, corner sequences
// and randomized traffic checked against a transaction-level model.
module tb_sram_like_data_responder;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned LATENCY = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req, wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [31:0]       addr, wdata;
  logic              addr_ok, data_ok;
  logic [31:0]       rdata;
  logic              stall_req, stall_rsp;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  always #5 clk = ~clk;

  sram_like_data_responder #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .data_sram_req    (req),
    .data_sram_wr     (wr),
    .data_sram_size   (size),
    .data_sram_wstrb  (wstrb),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata),
    .data_sram_addr_ok(addr_ok),
    .data_sram_data_ok(data_ok),
    .data_sram_rdata  (rdata),
    .stall_req        (stall_req),
    .stall_rsp        (stall_rsp),
    .ram_en           (ram_en),
    .ram_we           (ram_we),
    .ram_addr         (ram_addr),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata)
  );

  // Backing synchronous RAM (environment, not the reference model).
  logic [31:0] mem  [2**ADDR_W];
  logic [31:0] gmem [2**ADDR_W];

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++) if (ram_we[b]) mem[ram_addr][b*8+:8] <= ram_wdata[b*8+:8];
      ram_rdata <= mem[ram_addr];
    end
  end

  // Reference model: expected responses with the cycle they become due.
  typedef struct {
    logic        wr;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q[$];
  int   cyc_n  = 0;
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
  endtask

  task automatic cyc(input logic rq, input logic w, input logic [3:0] strb, input logic [31:0] a,
                     input logic [31:0] d, input logic sreq, input logic srsp, input logic rst,
                     output logic aok, output logic dok, output logic [31:0] rd);
    logic        e_aok, e_dok, hs;
    logic [31:0] e_rd, cur;
    req = rq; wr = w; wstrb = strb; addr = a; wdata = d;
    stall_req = sreq; stall_rsp = srsp; reset = rst;
    size = 2'd2;
    @(negedge clk);
    e_aok = !rst && !sreq && (q.size() < DEPTH);
    hs    = rq && e_aok;
    e_dok = !rst && (q.size() > 0) && (q[0].due <= cyc_n) && !srsp;
    e_rd  = (e_dok && !q[0].wr) ? q[0].data : 32'h0;
    aok = addr_ok; dok = data_ok; rd = rdata;
    chk("addr_ok", {31'b0, addr_ok}, {31'b0, e_aok});
    chk("data_ok", {31'b0, data_ok}, {31'b0, e_dok});
    chk("rdata", rdata, e_rd);
    chk("ram_en", {31'b0, ram_en}, {31'b0, hs});
    chk("ram_we", {28'b0, ram_we}, (hs && w) ? {28'b0, strb} : 32'h0);
    if (hs) begin
      chk("ram_addr", {18'b0, ram_addr}, {18'b0, a[ADDR_W+1:2]});
      chk("ram_wdata", ram_wdata, d);
    end
    if (rst) q.delete();
    else begin
      if (e_dok) void'(q.pop_front());
      if (hs) begin
        cur = gmem[a[ADDR_W+1:2]];
        if (w) begin
          for (int b = 0; b < 4; b++) if (strb[b]) cur[b*8+:8] = d[b*8+:8];
          gmem[a[ADDR_W+1:2]] = cur;
        end
        q.push_back('{wr: w, data: w ? 32'h0 : cur, due: cyc_n + LATENCY});
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rq, w;
    logic [3:0]  strb;
    logic [31:0] a, d;
    logic        e_aok, e_dok;
    logic [31:0] e_rd;
  } vec_t;
  vec_t tbl [9];

  logic        aok, dok;
  logic [31:0] rd;
  logic [4:0]  aok_seq;
  int          acc, n_dok;
  logic        p_rq, p_w;
  logic [3:0]  p_strb;
  logic [31:0] p_a, p_d;

  task automatic idle(input int n);
    logic a_, d_;
    logic [31:0] r_;
    for (int i = 0; i < n; i++) cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, a_, d_, r_);
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin mem[i] = 32'h0; gmem[i] = 32'h0; end
    ram_rdata = 32'h0;
    tbl[0] = '{1'b1, 1'b1, 4'hF, 32'h100, 32'h12345678, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h12345678};
    tbl[4] = '{1'b1, 1'b1, 4'h2, 32'h100, 32'h0000AB00, 1'b1, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h0};
    tbl[7] = '{1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h1234AB78};
    tbl[8] = '{1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0};

    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc(1, 0, 4'h0, 32'h40, 32'h0, 0, 0, 1, aok, dok, rd);

    // Write/read and partial-strobe merge at fixed latency.
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].rq, tbl[i].w, tbl[i].strb, tbl[i].a, tbl[i].d, 0, 0, 0, aok, dok, rd);
      chk($sformatf("tbl%0d_aok", i), {31'b0, aok}, {31'b0, tbl[i].e_aok});
      chk($sformatf("tbl%0d_dok", i), {31'b0, dok}, {31'b0, tbl[i].e_dok});
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].e_rd);
    end

    // Request held high against a full FIFO.
    acc = 0; aok_seq = '0;
    for (int i = 0; i < 12 && acc < 4; i++) begin
      cyc(1, 0, 4'h0, 32'h100 + 32'(acc * 4), 32'h0, 0, 0, 0, aok, dok, rd);
      if (i < 5) aok_seq[4-i] = aok;
      if (aok) acc++;
    end
    chk("hold_accepts", 32'(acc), 32'd4);
    chk("hold_aok_pattern", {27'b0, aok_seq}, 32'b11011);
    idle(4);

    // Response stall over two completed reads.
    cyc(1, 1, 4'hF, 32'h0, 32'hA, 0, 0, 0, aok, dok, rd);
    cyc(1, 1, 4'hF, 32'h4, 32'hB, 0, 0, 0, aok, dok, rd);
    idle(4);
    n_dok = 0;
    cyc(1, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0, aok, dok, rd); n_dok += int'(dok);
    cyc(1, 0, 4'h0, 32'h4, 32'h0, 0, 1, 0, aok, dok, rd); n_dok += int'(dok);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0, aok, dok, rd); n_dok += int'(dok);
    end
    chk("stall_rsp_quiet", 32'(n_dok), 32'd0);
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, aok, dok, rd);
    chk("stall_rel_first", dok ? rd : 32'hDEAD, 32'hA);
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, aok, dok, rd);
    chk("stall_rel_second", dok ? rd : 32'hDEAD, 32'hB);
    idle(2);

    // Reset while two reads are outstanding.
    cyc(1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, aok, dok, rd);
    cyc(1, 0, 4'h0, 32'h4, 32'h0, 0, 0, 0, aok, dok, rd);
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, aok, dok, rd);
    n_dok = int'(dok);
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, aok, dok, rd);
    chk("post_reset_aok", {31'b0, aok}, 32'd1);
    n_dok += int'(dok);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, aok, dok, rd); n_dok += int'(dok);
    end
    chk("reset_drops_rsp", 32'(n_dok), 32'd0);

    // Address-phase stall.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 4'h0, 32'h100, 32'h0, 1, 0, 0, aok, dok, rd);
      chk("stall_req_aok", {31'b0, aok}, 32'd0);
    end
    cyc(1, 0, 4'h0, 32'h100, 32'h0, 0, 0, 0, aok, dok, rd);
    chk("stall_req_release", {31'b0, aok}, 32'd1);
    idle(4);

    // Random traffic; requests held stable until accepted.
    p_rq = 0; p_w = 0; p_strb = '0; p_a = '0; p_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p_rq && $urandom_range(0, 9) < 6) begin
        p_rq   = 1'b1;
        p_w    = 1'($urandom_range(0, 1));
        p_strb = 4'($urandom);
        p_a    = 32'h200 + 32'($urandom_range(0, 15) * 4);
        p_d    = $urandom;
      end
      cyc(p_rq, p_w, p_strb, p_a, p_d, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, 0,
          aok, dok, rd);
      if (aok && p_rq) p_rq = 1'b0;
    end
    idle(6);
    chk("drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
